instruction_fetch_stage: RTL and testbench

Fetch stage of the 5-stage pipelined datapath. Owns the program counter and drives the byte address into the instruction memory. Latches the returned 16-bit instruction into the IF/ID pipeline register for decode. Handles stall, flush and branch/jump redirect from later stages, and detects the reserved halt opcode.

---
 rtl/instruction_fetch_stage.sv | 129 ++++++++++++
 tb/tb_instruction_fetch_stage.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_stage.sv
// Instruction fetch stage: owns the PC, drives the instruction memory address and
// fills the IF/ID register, handling stall, flush, redirect and the halt opcode.
module instruction_fetch_stage #(
  parameter int unsigned N        = 16,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic [15:0] ReadAddress,
  input  logic [15:0] Instruction,
  output logic [15:0] if_id_instr,
  output logic [15:0] if_id_pc,
  output logic        if_id_valid,
  output logic        halted,
  output logic [15:0] fetch_count
);

  localparam int unsigned AW        = 16;
  localparam logic [AW:0] MEM_BYTES = (AW + 1)'(2 * N);
  localparam logic [3:0]  HALT_OP   = 4'hF;

  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

  state_t          state, state_nx;
  logic [AW-1:0]   pc, pc_nx, pc_plus2, target_pc;
  logic [AW-1:0]   instr_nx, ipc_nx, cnt_nx;
  logic            valid_nx, halted_nx;
  logic            in_range;

  assign ReadAddress = pc;
  assign pc_plus2    = pc + AW'(2);
  assign target_pc   = redirect_pc & 16'hFFFE;
  assign in_range    = {1'b0, pc} < MEM_BYTES;

  // State, PC and IF/ID register
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= BOOT;
      pc          <= RESET_PC;
      if_id_instr <= '0;
      if_id_pc    <= '0;
      if_id_valid <= 1'b0;
      halted      <= 1'b0;
      fetch_count <= '0;
    end else begin
      state       <= state_nx;
      pc          <= pc_nx;
      if_id_instr <= instr_nx;
      if_id_pc    <= ipc_nx;
      if_id_valid <= valid_nx;
      halted      <= halted_nx;
      fetch_count <= cnt_nx;
    end
  end

  // Next state, next PC and IF/ID contents
  always_comb begin
    state_nx  = state;
    pc_nx     = pc;
    instr_nx  = if_id_instr;
    ipc_nx    = if_id_pc;
    valid_nx  = if_id_valid;
    halted_nx = 1'b0;
    cnt_nx    = fetch_count;

    case (state)
      BOOT: begin
        state_nx = RUN;
      end

      RUN: begin
        if (redirect) begin
          pc_nx    = target_pc;
          instr_nx = '0;
          ipc_nx   = '0;
          valid_nx = 1'b0;
        end else if (stall) begin
          // Hold PC and IF/ID; a concurrent flush still squashes the held entry
          if (flush) begin
            instr_nx = '0;
            ipc_nx   = '0;
            valid_nx = 1'b0;
          end
        end else if (flush) begin
          pc_nx    = pc_plus2;
          instr_nx = '0;
          ipc_nx   = '0;
          valid_nx = 1'b0;
        end else begin
          pc_nx = pc_plus2;
          if (in_range) begin
            instr_nx = Instruction;
            ipc_nx   = pc_plus2;
            valid_nx = 1'b1;
            cnt_nx   = fetch_count + AW'(1);
            if (Instruction[15:12] == HALT_OP) begin
              state_nx = HALT;
            end
          end else begin
            instr_nx = '0;
            ipc_nx   = '0;
            valid_nx = 1'b0;
          end
        end
      end

      HALT: begin
        instr_nx = '0;
        ipc_nx   = '0;
        valid_nx = 1'b0;
        if (redirect) begin
          pc_nx    = target_pc;
          state_nx = RUN;
        end else begin
          halted_nx = 1'b1;
        end
      end

      default: begin
        state_nx = BOOT;
      end
    endcase
  end

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Directed bench for instruction_fetch_stage with a behavioural 16-word instruction memory.
module tb_instruction_fetch_stage;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        flush;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic [15:0] ReadAddress;
  logic [15:0] Instruction;
  logic [15:0] if_id_instr;
  logic [15:0] if_id_pc;
  logic        if_id_valid;
  logic        halted;
  logic [15:0] fetch_count;

  logic [15:0] mem [16];
  int          n_checks;
  int          n_fail;

  instruction_fetch_stage #(.N(16), .RESET_PC(16'h0000)) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .flush       (flush),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .ReadAddress (ReadAddress),
    .Instruction (Instruction),
    .if_id_instr (if_id_instr),
    .if_id_pc    (if_id_pc),
    .if_id_valid (if_id_valid),
    .halted      (halted),
    .fetch_count (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Out-of-range reads return a non-zero pattern so a missed bubble is visible
  assign Instruction = (ReadAddress < 16'd32) ? mem[ReadAddress[4:1]] : 16'hDEAD;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_ifid(input string tag, input logic [15:0] instr,
                             input logic [15:0] pc, input logic valid);
    check({tag, ".instr"}, if_id_instr, instr);
    check({tag, ".pc"},    if_id_pc,    pc);
    check({tag, ".valid"}, 16'(if_id_valid), 16'(valid));
  endtask

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    rst         = 1'b1;
    stall       = 1'b0;
    flush       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 16'h0000;
    for (int i = 0; i < 16; i++) mem[i] = 16'h3000 + 16'(i);
    mem[0] = 16'h1010;
    mem[1] = 16'h1010;
    mem[2] = 16'h1000;
    mem[3] = 16'h1011;

    // Reset state
    tick();
    expect_ifid("rst", 16'h0000, 16'h0000, 1'b0);
    check("rst.ra",     ReadAddress, 16'h0000);
    check("rst.halted", 16'(halted), 16'd0);
    check("rst.count",  fetch_count, 16'h0000);

    // BOOT cycle: no capture
    rst = 1'b0;
    tick();
    expect_ifid("boot", 16'h0000, 16'h0000, 1'b0);
    check("boot.ra", ReadAddress, 16'h0000);

    tick(); expect_ifid("f0", 16'h1010, 16'h0002, 1'b1); check("f0.ra", ReadAddress, 16'h0002);
    tick(); expect_ifid("f1", 16'h1010, 16'h0004, 1'b1);
    tick(); expect_ifid("f2", 16'h1000, 16'h0006, 1'b1); check("f2.count", fetch_count, 16'd3);

    // Stall holds IF/ID and PC
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_ifid("stall", 16'h1000, 16'h0006, 1'b1);
      check("stall.ra",    ReadAddress, 16'h0006);
      check("stall.count", fetch_count, 16'd3);
    end
    stall = 1'b0;
    tick(); expect_ifid("f3", 16'h1011, 16'h0008, 1'b1); check("f3.count", fetch_count, 16'd4);

    // Mid-stream reset pulse
    rst = 1'b1;
    tick();
    expect_ifid("rst2", 16'h0000, 16'h0000, 1'b0);
    check("rst2.ra",    ReadAddress, 16'h0000);
    check("rst2.count", fetch_count, 16'h0000);
    rst = 1'b0;
    tick(); expect_ifid("boot2", 16'h0000, 16'h0000, 1'b0);
    tick(); expect_ifid("g0", 16'h1010, 16'h0002, 1'b1);
    tick(); expect_ifid("g1", 16'h1010, 16'h0004, 1'b1); check("g1.ra", ReadAddress, 16'h0004);

    // Redirect to odd target with stall high: bit 0 dropped, redirect wins
    redirect = 1'b1; redirect_pc = 16'h000B; stall = 1'b1;
    tick();
    expect_ifid("redir", 16'h0000, 16'h0000, 1'b0);
    check("redir.ra", ReadAddress, 16'h000A);
    redirect = 1'b0; stall = 1'b0;
    tick(); expect_ifid("tgt", 16'h3005, 16'h000C, 1'b1); check("tgt.count", fetch_count, 16'd3);

    // Flush alone advances PC; flush with stall holds PC
    flush = 1'b1;
    tick(); expect_ifid("flush", 16'h0000, 16'h0000, 1'b0); check("flush.ra", ReadAddress, 16'h000E);
    stall = 1'b1;
    tick(); expect_ifid("stfl", 16'h0000, 16'h0000, 1'b0); check("stfl.ra", ReadAddress, 16'h000E);
    stall = 1'b0; flush = 1'b0;
    tick(); expect_ifid("h0", 16'h3007, 16'h0010, 1'b1); check("h0.count", fetch_count, 16'd4);

    // Last in-range word, then out-of-range bubbles with frozen count
    redirect = 1'b1; redirect_pc = 16'h001E;
    tick(); expect_ifid("r1e", 16'h0000, 16'h0000, 1'b0);
    redirect = 1'b0;
    tick(); expect_ifid("last", 16'h300F, 16'h0020, 1'b1); check("last.ra", ReadAddress, 16'h0020);
    tick(); expect_ifid("oor0", 16'h0000, 16'h0000, 1'b0); check("oor0.count", fetch_count, 16'd5);
    tick(); expect_ifid("oor1", 16'h0000, 16'h0000, 1'b0); check("oor1.count", fetch_count, 16'd5);
    check("oor1.ra", ReadAddress, 16'h0024);

    // Redirect to FFFE: out-of-range bubble, then PC wraps to 0
    redirect = 1'b1; redirect_pc = 16'hFFFE;
    tick(); expect_ifid("rfffe", 16'h0000, 16'h0000, 1'b0); check("rfffe.ra", ReadAddress, 16'hFFFE);
    redirect = 1'b0;
    tick(); expect_ifid("wrap", 16'h0000, 16'h0000, 1'b0); check("wrap.ra", ReadAddress, 16'h0000);
    tick(); expect_ifid("w0", 16'h1010, 16'h0002, 1'b1); check("w0.count", fetch_count, 16'd6);

    // Halt opcode at byte address 4
    mem[2] = 16'hF000;
    tick(); expect_ifid("w1", 16'h1010, 16'h0004, 1'b1);
    tick(); expect_ifid("hlt", 16'hF000, 16'h0006, 1'b1);
    check("hlt.halted", 16'(halted), 16'd0);
    check("hlt.count",  fetch_count, 16'd8);
    for (int i = 0; i < 5; i++) begin
      stall = (i == 1 || i == 3);
      flush = (i == 2 || i == 3);
      tick();
      expect_ifid("hbub", 16'h0000, 16'h0000, 1'b0);
      check("hbub.halted", 16'(halted), 16'd1);
      check("hbub.ra",     ReadAddress, 16'h0006);
      check("hbub.count",  fetch_count, 16'd8);
    end
    stall = 1'b0; flush = 1'b0;
    redirect = 1'b1; redirect_pc = 16'h0000;
    tick();
    expect_ifid("hredir", 16'h0000, 16'h0000, 1'b0);
    check("hredir.halted", 16'(halted), 16'd0);
    check("hredir.ra",     ReadAddress, 16'h0000);
    redirect = 1'b0;
    tick(); expect_ifid("refetch", 16'h1010, 16'h0002, 1'b1); check("refetch.count", fetch_count, 16'd9);

    // Reset beats a simultaneous redirect
    rst = 1'b1; redirect = 1'b1; redirect_pc = 16'h0010;
    tick();
    expect_ifid("rst3", 16'h0000, 16'h0000, 1'b0);
    check("rst3.ra",    ReadAddress, 16'h0000);
    check("rst3.count", fetch_count, 16'h0000);
    rst = 1'b0; redirect = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
